// File: rtl/bcd_chain_updown_counter.sv
// Multi-digit up/down counter with a per-digit modulus, cascaded within one cycle.
// Optional HOLD_AT_LIMIT_EN: saturate at the chain limits instead of wrapping.
module bcd_chain_updown_counter #(
    parameter int                  DIGITS   = 4,
    parameter logic [5*DIGITS-1:0] MOD_LIST = {5'd6, 5'd10, 5'd6, 5'd10}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  reverse,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_val,
    output logic [DIGITS*4-1:0]   count,
    output logic                  carry_out,
    output logic                  at_zero,
    output logic                  at_max
);

    logic [DIGITS*4-1:0] count_q;
    logic [DIGITS*4-1:0] count_d;
    logic [DIGITS-1:0]   dig_max;
    logic [DIGITS-1:0]   dig_zero;
    logic [DIGITS-1:0]   chain_ok;
    logic                chain_limit;
    logic                hold_limit;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [4:0] MODV = MOD_LIST[5*gi +: 5];
            localparam logic [3:0] MAXV = 4'(MODV - 5'd1);

            if (MODV < 5'd2 || MODV > 5'd16) begin : g_bad_mod
                $error("bcd_chain_updown_counter: digit modulus out of range 2..16");
            end

            logic [3:0] cur_dig;
            logic [3:0] ld_dig;
            logic [3:0] ld_clamp;
            logic [3:0] step_dig;

            assign cur_dig  = count_q[4*gi +: 4];
            assign ld_dig   = load_val[4*gi +: 4];
            assign ld_clamp = (ld_dig > MAXV) ? MAXV : ld_dig;
            assign dig_max[gi]  = (cur_dig == MAXV);
            assign dig_zero[gi] = (cur_dig == 4'd0);

            assign step_dig = reverse ? (dig_zero[gi] ? MAXV : cur_dig - 4'd1)
                                      : (dig_max[gi]  ? 4'd0 : cur_dig + 4'd1);

            assign count_d[4*gi +: 4] = clear ? 4'd0 :
                                        load  ? ld_clamp :
                                        (enable && chain_ok[gi] && !hold_limit) ? step_dig :
                                        cur_dig;
        end
    endgenerate

    // A digit steps only when every lower digit sits at its rollover value
    // for the current direction.
    always_comb begin
        chain_ok    = '0;
        chain_ok[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            chain_ok[i] = chain_ok[i-1] & (reverse ? dig_zero[i-1] : dig_max[i-1]);
        end
    end

    assign chain_limit = reverse ? (&dig_zero) : (&dig_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef HOLD_AT_LIMIT_EN
    assign hold_limit = chain_limit;
    assign carry_out  = 1'b0;
`else
    logic carry_q;
    logic carry_d;

    assign hold_limit = 1'b0;
    assign carry_d    = !clear && !load && enable && chain_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
`endif

    assign count   = count_q;
    assign at_zero = (count_q == '0);
    assign at_max  = &dig_max;

endmodule

// File: tb/tb_bcd_chain_updown_counter.sv
// Directed-vector bench for the default MM:SS chain with hand-computed expectations.
module tb_bcd_chain_updown_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        reverse;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry_out;
    logic        at_zero;
    logic        at_max;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_chain_updown_counter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .reverse   (reverse),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .carry_out (carry_out),
        .at_zero   (at_zero),
        .at_max    (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        reverse  = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
        tick();
        check_val("rst_count", 32'(count), 32'h0000);
        check_val("rst_carry", 32'(carry_out), 32'h0);
        check_val("rst_at_zero", 32'(at_zero), 32'h1);
        check_val("rst_at_max", 32'(at_max), 32'h0);

        #2 reset = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_val("first_up", 32'(count), 32'h0001);
        check_val("first_up_carry", 32'(carry_out), 32'h0);

        do_load(16'h0959);
        check_val("load_0959", 32'(count), 32'h0959);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_val("cascade3_up", 32'(count), 32'h1000);
        check_val("cascade3_carry", 32'(carry_out), 32'h0);

        do_load(16'h5959);
        check_val("at_max_5959", 32'(at_max), 32'h1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
`ifdef HOLD_AT_LIMIT_EN
        check_val("wrap_up_count", 32'(count), 32'h5959);
        check_val("wrap_up_carry", 32'(carry_out), 32'h0);
        do_load(16'h0000);
`else
        check_val("wrap_up_count", 32'(count), 32'h0000);
        check_val("wrap_up_carry", 32'(carry_out), 32'h1);
        check_val("wrap_up_at_zero", 32'(at_zero), 32'h1);
        tick();
        check_val("carry_one_cycle", 32'(carry_out), 32'h0);
`endif

        reverse = 1'b1;
        enable  = 1'b1;
        tick();
        enable  = 1'b0;
`ifdef HOLD_AT_LIMIT_EN
        check_val("borrow_count", 32'(count), 32'h0000);
        check_val("borrow_carry", 32'(carry_out), 32'h0);
        do_load(16'h5959);
`else
        check_val("borrow_count", 32'(count), 32'h5959);
        check_val("borrow_carry", 32'(carry_out), 32'h1);
        check_val("borrow_at_max", 32'(at_max), 32'h1);
        tick();
        check_val("hold_count", 32'(count), 32'h5959);
        check_val("hold_carry", 32'(carry_out), 32'h0);
`endif

        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_val("down_5958", 32'(count), 32'h5958);

        do_load(16'h1000);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_val("cascade3_down", 32'(count), 32'h0959);
        check_val("cascade3_down_carry", 32'(carry_out), 32'h0);

        reverse = 1'b0;
        enable  = 1'b1;
        do_load(16'h0123);
        enable  = 1'b0;
        check_val("load_over_enable", 32'(count), 32'h0123);

        do_load(16'h0F0C);
        check_val("load_clamp_0F0C", 32'(count), 32'h0909);
        do_load(16'hFFFF);
        check_val("load_clamp_FFFF", 32'(count), 32'h5959);

        clear = 1'b1;
        load  = 1'b1;
        enable = 1'b1;
        load_val = 16'h1234;
        tick();
        clear = 1'b0;
        load  = 1'b0;
        enable = 1'b0;
        check_val("clear_over_load", 32'(count), 32'h0000);
        check_val("clear_carry", 32'(carry_out), 32'h0);

        do_load(16'h0058);
        enable = 1'b1;
        tick();
        check_val("up_0059", 32'(count), 32'h0059);
        tick();
        check_val("up_0100", 32'(count), 32'h0100);
        reverse = 1'b1;
        tick();
        check_val("rev_toggle_0059", 32'(count), 32'h0059);
        reverse = 1'b0;
        tick();
        check_val("up_again_0100", 32'(count), 32'h0100);

        #3 reset = 1'b1;
        #1;
        check_val("async_reset_count", 32'(count), 32'h0000);
        check_val("async_reset_carry", 32'(carry_out), 32'h0);
        enable = 1'b0;
        tick();
        #2 reset = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        tick();
        enable = 1'b0;
        check_val("resume_0003", 32'(count), 32'h0003);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
